// File: rtl/vliw_exec_cluster_pkg.sv
// vliw_exec_cluster_pkg: opcodes, slot field layout and decoded slot type
package vliw_exec_cluster_pkg;
  localparam int SLOT_W = 20;
  localparam int FIELD_W = 4;
  localparam int OP_LSB = 15;
  localparam int SRC1_LSB = 10;
  localparam int SRC2_LSB = 5;
  localparam int DEST_LSB = 0;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_MUL  = 4'h3,
    OP_LOAD = 4'h4,
    OP_MOVE = 4'h5,
    OP_READ = 4'h6,
    OP_JEQ  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'ha,
    OP_BSL  = 4'he,
    OP_BSR  = 4'hf
  } opcode_e;
  typedef struct packed {
    opcode_e op;
    logic [FIELD_W-1:0] src1;
    logic [FIELD_W-1:0] src2;
    logic [FIELD_W-1:0] dest;
  } slot_t;
endpackage

// File: rtl/vliw_exec_cluster_if.sv
// vliw_exec_cluster_if: bundle issue and read-result bus of the execute cluster
interface vliw_exec_cluster_if #(
  parameter int SLOTS = 3,
  parameter int DATA_W = 64
);
  localparam int WORD_W = 20 * SLOTS + 4;
  logic bundle_valid;
  logic [WORD_W-1:0] word;
  logic [SLOTS*DATA_W-1:0] data;
  logic [SLOTS*DATA_W-1:0] readdatapipe;
  logic [SLOTS-1:0] readdatavalid;
  logic jump;
  modport master (
    output bundle_valid, word, data,
    input  readdatapipe, readdatavalid, jump
  );
  modport slave (
    input  bundle_valid, word, data,
    output readdatapipe, readdatavalid, jump
  );
endinterface

// File: rtl/vliw_slot_alu.sv
// vliw_slot_alu: combinational execute for one issue slot
module vliw_slot_alu
  import vliw_exec_cluster_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] res,
  output logic              we,
  output logic              rd,
  output logic              eq
);
  localparam int SH_W = $clog2(DATA_W);
  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];
  always_comb begin
    res = '0;
    we = 1'b1;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_LOAD: res = imm;
      OP_MOVE: res = a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_BSL:  res = a << sh;
      OP_BSR:  res = a >> sh;
      default: we = 1'b0;
    endcase
  end
  assign rd = op == OP_READ;
  assign eq = op == OP_JEQ && a == b;
endmodule

// File: rtl/vliw_exec_cluster.sv
// vliw_exec_cluster: two-stage (decode register, execute/write-back) VLIW cluster
// with a shared register file; the highest slot wins on same-destination writes.
module vliw_exec_cluster
  import vliw_exec_cluster_pkg::*;
#(
  parameter int SLOTS = 3,
  parameter int DATA_W = 64,
  parameter int RADDR_W = 4
) (
  input logic clk,
  input logic rst_n,
  vliw_exec_cluster_if.slave bus
);
  localparam int NREG = 1 << RADDR_W;
  slot_t [SLOTS-1:0] d_nxt, d_slot, e_slot;
  logic [SLOTS*DATA_W-1:0] d_data, e_data;
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] rf_nxt [NREG];
  logic [DATA_W-1:0] a [SLOTS];
  logic [DATA_W-1:0] b [SLOTS];
  logic [DATA_W-1:0] res [SLOTS];
  logic [RADDR_W-1:0] dst [SLOTS];
  logic [SLOTS-1:0] we, rd, eq;
  logic unused_bits;
  assign unused_bits = ^bus.word;
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    localparam int B = SLOT_W * k;
    assign d_nxt[k] = bus.bundle_valid ? slot_t'{
      op:   opcode_e'(bus.word[B+OP_LSB +: FIELD_W]),
      src1: bus.word[B+SRC1_LSB +: FIELD_W],
      src2: bus.word[B+SRC2_LSB +: FIELD_W],
      dest: bus.word[B+DEST_LSB +: FIELD_W]
    } : slot_t'('0);
    assign a[k] = rf[e_slot[k].src1[RADDR_W-1:0]];
    assign b[k] = rf[e_slot[k].src2[RADDR_W-1:0]];
    assign dst[k] = e_slot[k].dest[RADDR_W-1:0];
    vliw_slot_alu #(.DATA_W(DATA_W)) u_alu (
      .op  (e_slot[k].op),
      .a   (a[k]),
      .b   (b[k]),
      .imm (e_data[DATA_W*k +: DATA_W]),
      .res (res[k]),
      .we  (we[k]),
      .rd  (rd[k]),
      .eq  (eq[k])
    );
  end
  // ascending slot order lets the highest-index writer override
  always_comb begin
    rf_nxt = rf;
    for (int k = 0; k < SLOTS; k++)
      if (we[k]) rf_nxt[dst[k]] = res[k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_slot <= '0;
      e_slot <= '0;
      d_data <= '0;
      e_data <= '0;
      rf <= '{default: '0};
      bus.readdatapipe <= '0;
      bus.readdatavalid <= '0;
      bus.jump <= 1'b0;
    end else begin
      d_slot <= d_nxt;
      d_data <= bus.bundle_valid ? bus.data : '0;
      e_slot <= d_slot;
      e_data <= d_data;
      rf <= rf_nxt;
      bus.readdatavalid <= rd;
      bus.jump <= |eq;
      for (int k = 0; k < SLOTS; k++)
        if (rd[k]) bus.readdatapipe[DATA_W*k +: DATA_W] <= a[k];
    end
  end
endmodule

// File: doc/vliw_exec_cluster.md
VLIW_EXEC_CLUSTER -- requirements
Module: vliw_exec_cluster

Interface
REQ-001 Parameter SLOTS, default 3: number of issue slots per bundle.
REQ-002 Parameter DATA_W, default 64: register and datapath width.
REQ-003 Parameter RADDR_W, default 4: register-address width, giving 2**RADDR_W registers.
REQ-004 Derived WORD_W = 20*SLOTS+4 (64 at default); bits above 20*SLOTS are reserved and ignored.
REQ-005 clock  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset is asynchronous and active-low.
REQ-007 bundle_valid  input  1  word/data hold a bundle this cycle.
REQ-008 word  input  WORD_W  slot k field = word[20k+19:20k]: opcode [18:15], src1 [13:10], src2 [8:5], dest [3:0]; bits 19/14/9/4 reserved.
REQ-009 data  input  SLOTS*DATA_W  slot k immediate = data[DATA_W*k +: DATA_W].
REQ-010 readdatapipe  output  SLOTS*DATA_W  slot k read result, same packing as data.
REQ-011 readdatavalid  output  SLOTS  per-slot read-result strobe.
REQ-012 jump  output  1  compare-equal taken strobe.

Function
REQ-013 Opcodes SHALL be: 0000 NOP, 0001 ADD, 0010 SUB, 0011 MUL, 0100 LOAD, 0101 MOVE, 0110 READ, 0111 JEQ, 1000 AND, 1001 OR, 1010 XOR, 1110 BSL, 1111 BSR; any other code executes as NOP.
REQ-014 Pipeline SHALL have two stages: D (bundle register, loaded when bundle_valid=1, otherwise loaded with all-NOP) and E (register-file read, execute, write-back at end of E).
REQ-015 A bundle sampled at edge t SHALL write its destinations and drive readdatapipe/readdatavalid/jump after edge t+2.
REQ-016 ADD/SUB/MUL SHALL produce DATA_W-bit results with wrap-around; MUL keeps the low DATA_W bits; SUB = src1-src2.
REQ-017 BSL/BSR SHALL shift src1 left/right logically by src2[log2(DATA_W)-1:0]; zero fill.
REQ-018 LOAD SHALL write the slot immediate to dest; MOVE SHALL write src1 to dest.
REQ-019 READ SHALL register src1 into the slot lane of readdatapipe and pulse readdatavalid[k] for exactly one cycle; non-READ lanes hold their last value, with valid=0.
REQ-020 JEQ SHALL pulse jump for one cycle when src1==src2 in any slot; no register write.
REQ-021 All operand reads in a bundle SHALL return pre-bundle register values; intra-bundle writes are not visible to the same bundle.
REQ-022 Consecutive bundles SHALL see prior results with no stall and no forwarding path; E writes before the next E reads.
REQ-023 When several slots write the same dest in one bundle, the highest-index slot SHALL win.
REQ-024 Register 0 SHALL be an ordinary writable register.

Reset
REQ-025 Assertion SHALL immediately clear all registers, the D bundle (to NOP), readdatapipe, readdatavalid and jump to zero.
REQ-026 Reset mid-operation SHALL discard in-flight bundles; after deassertion, the first sampled bundle completes per REQ-015.

Structure
REQ-027 A shared package SHALL hold the opcode constants, the slot field offsets and the 20-bit slot-field width.
REQ-028 One sub-module, vliw_slot_alu (combinational per-slot execute), SHALL be instantiated SLOTS times via generate; the register file and write-priority logic stay in the top.

Verification
REQ-029 Reset, then LOAD r0=123456789abcdef0, r1=1000000000000001, r2=0111111111111110 in one bundle; READ r0/r1/r2 next bundle -> lanes 2/1/0 show these values, readdatavalid=111 for one cycle, 2 cycles after sampling.
REQ-030 After loading r3=abababababababab and r4=100000aaa19a8654: BSL r3,r4->r10; SUB r0,r1->r11; MUL r2,r1->r12; then READ r10/r11/r12 -> bababababab00000, 023456789abcdeef, 0111111111111110.
REQ-031 Slots 2 and 0 both LOAD r5 (1111... and 2222...) in one bundle, slot 1 READ r5 in the same bundle -> read returns the old r5; the next READ r5 returns 1111111111111111.
REQ-032 JEQ r6,r6 in slot 1 with others NOP -> jump=1 for exactly one cycle; JEQ r0,r1 -> jump stays 0.
REQ-033 bundle_valid=0 for 3 cycles between bundles -> no register change, readdatavalid=000, outputs hold.
REQ-034 Assert reset while a LOAD r7 is in E -> r7 reads 0 after release; all outputs are 0 during reset.
